// File: rtl/checksum_pkg.sv
// checksum_pkg: shared definitions for the streaming ones'-complement
// checksum block.
//   SUM_W_DEF  : default checksum word width.
//   FOLD_MAX_W : widest value eac_fold accepts.
//   state_t    : control FSM states.
//   eac_fold   : one end-around-carry step at a runtime word width.
package checksum_pkg;

  localparam int unsigned SUM_W_DEF  = 16;
  localparam int unsigned FOLD_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_FOLD,
    ST_DONE
  } state_t;

  // Adds the bits above position w back into the low w bits.
  function automatic logic [FOLD_MAX_W-1:0] eac_fold(
    input logic [FOLD_MAX_W-1:0] x,
    input int unsigned           w
  );
    logic [FOLD_MAX_W-1:0] mask;
    mask = (FOLD_MAX_W'(1) << w) - FOLD_MAX_W'(1);
    return (x & mask) + (x >> w);
  endfunction

endpackage

// File: rtl/checksum_fold.sv
// checksum_fold: combinational end-around-carry fold of an IN_W-bit sum
// down to OUT_W bits. Two fold steps are enough whenever
// IN_W - OUT_W <= OUT_W.
//   x : wide unsigned sum (IN_W bits)
//   y : folded ones'-complement value (OUT_W bits)
module checksum_fold
  import checksum_pkg::*;
#(
  parameter int unsigned IN_W  = 19,
  parameter int unsigned OUT_W = SUM_W_DEF
) (
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] y
);

  logic [FOLD_MAX_W-1:0] once;

  always_comb begin
    once = eac_fold(FOLD_MAX_W'(x), OUT_W);
    y    = OUT_W'(eac_fold(once, OUT_W));
  end

endmodule

// File: rtl/checksum_stream.sv
// checksum_stream: streaming ones'-complement checksum over packets made of
// DATA_W-bit beats, producing one SUM_W-bit result per packet.
//   clk, nreset  : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o / in_start_i / in_last_i : beat handshake/framing
//   in_keep_i    : byte enables (a cleared bit zeroes its byte)
//   in_data_i    : payload, word i = in_data_i[i*SUM_W +: SUM_W]
//   init_i       : seed partial sum, taken on the accepted start beat
//   cs_valid_o / cs_ready_i : result handshake
//   cs_o         : ones'-complement checksum (~acc)
//   cs_err_o     : verify failure flag
// Optional feature macro: CHECKSUM_VERIFY_EN (cs_err_o = final acc != all-ones;
// when undefined cs_err_o is tied low).
module checksum_stream
  import checksum_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned SUM_W  = SUM_W_DEF
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                in_start_i,
  input  logic                in_last_i,
  input  logic [DATA_W/8-1:0] in_keep_i,
  input  logic [DATA_W-1:0]   in_data_i,
  input  logic [SUM_W-1:0]    init_i,
  output logic                cs_valid_o,
  input  logic                cs_ready_i,
  output logic [SUM_W-1:0]    cs_o,
  output logic                cs_err_o
);

  localparam int unsigned N      = DATA_W / SUM_W;
  localparam int unsigned KEEP_W = DATA_W / 8;
  // N words plus one base term fit in SUM_W + clog2(N+1) bits.
  localparam int unsigned BS_W   = SUM_W + $clog2(N + 1);

  state_t state, state_next;

  logic [SUM_W-1:0]  acc;
  logic [DATA_W-1:0] masked;
  logic [BS_W-1:0]   beat_sum;
  logic [BS_W-1:0]   sum_in;
  logic [SUM_W-1:0]  base;
  logic [SUM_W-1:0]  folded;
  logic              accept;
  logic              load;

  assign accept = in_valid_i && in_ready_o;
  // In IDLE only a start beat opens a packet; anything else is dropped.
  assign load   = accept && ((state == ST_ACC) || in_start_i);

  // Beat sum of the byte-masked words.
  always_comb begin
    masked = in_data_i;
    for (int unsigned b = 0; b < KEEP_W; b++) begin
      if (!in_keep_i[b]) masked[b*8 +: 8] = '0;
    end
    beat_sum = '0;
    for (int unsigned i = 0; i < N; i++) begin
      beat_sum = beat_sum + BS_W'(masked[i*SUM_W +: SUM_W]);
    end
  end

  // A start beat (in IDLE or restarting in ACC) seeds from init_i.
  assign base   = ((state == ST_IDLE) || in_start_i) ? init_i : acc;
  assign sum_in = beat_sum + BS_W'(base);

  checksum_fold #(
    .IN_W  (BS_W),
    .OUT_W (SUM_W)
  ) u_fold (
    .x (sum_in),
    .y (folded)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ST_IDLE;
    else         state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (accept && in_start_i) state_next = in_last_i ? ST_FOLD : ST_ACC;
      ST_ACC:  if (accept && in_last_i)  state_next = ST_FOLD;
      ST_FOLD: state_next = ST_DONE;
      ST_DONE: if (cs_ready_i)           state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready_o = (state == ST_IDLE) || (state == ST_ACC);
    cs_valid_o = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)   acc <= '0;
    else if (load) acc <= folded;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)                cs_o <= '0;
    else if (state == ST_FOLD)  cs_o <= ~acc;
  end

`ifdef CHECKSUM_VERIFY_EN
  // A packet carrying its own checksum sums to all-ones when intact.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)                cs_err_o <= 1'b0;
    else if (state == ST_FOLD)  cs_err_o <= (acc != '1);
  end
`else
  assign cs_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_checksum_stream.sv
module tb_checksum_stream;

  localparam int DATA_W = 32;
  localparam int SUM_W  = 16;

  logic                clk = 1'b0;
  logic                nreset = 1'b0;
  logic                in_valid_i = 1'b0;
  logic                in_ready_o;
  logic                in_start_i = 1'b0;
  logic                in_last_i = 1'b0;
  logic [DATA_W/8-1:0] in_keep_i = '0;
  logic [DATA_W-1:0]   in_data_i = '0;
  logic [SUM_W-1:0]    init_i = '0;
  logic                cs_valid_o;
  logic                cs_ready_i = 1'b1;
  logic [SUM_W-1:0]    cs_o;
  logic                cs_err_o;

  checksum_stream #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_start_i (in_start_i),
    .in_last_i  (in_last_i),
    .in_keep_i  (in_keep_i),
    .in_data_i  (in_data_i),
    .init_i     (init_i),
    .cs_valid_o (cs_valid_o),
    .cs_ready_i (cs_ready_i),
    .cs_o       (cs_o),
    .cs_err_o   (cs_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] cs;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: whole-packet sum as a plain integer.
  longint unsigned pkt_sum = 0;
  bit              in_pkt  = 0;

  bit   rand_ready  = 0;
  logic ready_force = 1'b1;

  always @(posedge clk) begin
    #1;
    cs_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic longint unsigned beat_words(input logic [31:0] d, input logic [3:0] k);
    logic [31:0] m;
    m = d;
    for (int b = 0; b < 4; b++) if (!k[b]) m[b*8 +: 8] = 8'h00;
    return 64'(m[15:0]) + 64'(m[31:16]);
  endfunction

  // Ones'-complement value of a whole sum: fold until it fits 16 bits.
  function automatic logic [15:0] ones_sum(input longint unsigned s);
    longint unsigned v;
    v = s;
    while (v > 64'hFFFF) v = (v & 64'hFFFF) + (v >> 16);
    return 16'(v);
  endfunction

  task automatic push_expected();
    exp_t e;
    logic [15:0] a;
    a = ones_sum(pkt_sum);
    e.cs = ~a;
`ifdef CHECKSUM_VERIFY_EN
    e.err = (a != 16'hFFFF);
`else
    e.err = 1'b0;
`endif
    exp_q.push_back(e);
  endtask

  // Offer one beat until accepted; update the model on acceptance.
  task automatic send_beat(input bit st, input bit ls, input logic [31:0] d,
                           input logic [3:0] k, input logic [15:0] ini);
    bit rdy;
    int n;
    n = 0;
    in_valid_i = 1'b1; in_start_i = st; in_last_i = ls;
    in_data_i = d; in_keep_i = k; init_i = ini;
    do begin
      @(negedge clk); rdy = in_ready_o;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 100);
    in_valid_i = 1'b0;
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL accept_timeout: beat not accepted within 100 cycles");
      return;
    end
    if (st) begin
      in_pkt  = 1;
      pkt_sum = 64'(ini) + beat_words(d, k);
    end else if (in_pkt) begin
      pkt_sum += beat_words(d, k);
    end
    if (in_pkt && ls) begin
      push_expected();
      in_pkt = 0;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cs_valid_o) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
    end
  endtask

  // Monitor: pops one expectation per presented result and checks that
  // the result holds steady while cs_ready_i is low.
  bit          holding = 0;
  logic [15:0] held_cs;
  logic        held_err;
  always @(negedge clk) begin
    exp_t e;
    if (cs_valid_o) begin
      if (!holding) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got cs 0x%0h, expected none", cs_o);
        end else begin
          e = exp_q.pop_front();
          check("cs_o", 32'(cs_o), 32'(e.cs));
          check("cs_err_o", 32'(cs_err_o), 32'(e.err));
        end
        held_cs = cs_o; held_err = cs_err_o; holding = 1;
      end else begin
        check("cs_o_stable", 32'(cs_o), 32'(held_cs));
        check("cs_err_stable", 32'(cs_err_o), 32'(held_err));
      end
      if (cs_ready_i) holding = 0;
    end else begin
      holding = 0;
    end
  end

  initial begin
    // Reset values
    #2;
    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    check("rst_cs_valid", 32'(cs_valid_o), 32'd0);
    check("rst_cs_o", 32'(cs_o), 32'd0);
    check("rst_cs_err", 32'(cs_err_o), 32'd0);
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;

    // Single-beat packet and T+2 latency
    send_beat(1, 1, 32'h0001FFFF, 4'hF, 16'h0000);
    @(negedge clk);
    check("lat_fold_not_valid", 32'(cs_valid_o), 32'd0);
    check("lat_fold_not_ready", 32'(in_ready_o), 32'd0);
    @(negedge clk);
    check("lat_t2_valid", 32'(cs_valid_o), 32'd1);
    wait_drain();

    // Two-beat packet
    send_beat(1, 0, 32'h12345678, 4'hF, 16'h0000);
    send_beat(0, 1, 32'h9ABCDEF0, 4'hF, 16'h0000);
    wait_drain();

    // Byte masking
    send_beat(1, 1, 32'hFFFFFFFF, 4'h1, 16'h0000);
    wait_drain();
    send_beat(1, 1, 32'hFFFFFFFF, 4'h0, 16'h0000);
    wait_drain();
    send_beat(1, 1, 32'h00000000, 4'hF, 16'h0000);
    wait_drain();

    // Packet carrying its own checksum, intact and with one bit flipped
    send_beat(1, 0, 32'h12345678, 4'hF, 16'h0000);
    send_beat(0, 0, 32'h9ABCDEF0, 4'hF, 16'h0000);
    send_beat(0, 1, 32'h00001DA6, 4'hF, 16'h0000);
    wait_drain();
    send_beat(1, 0, 32'h12345679, 4'hF, 16'h0000);
    send_beat(0, 0, 32'h9ABCDEF0, 4'hF, 16'h0000);
    send_beat(0, 1, 32'h00001DA6, 4'hF, 16'h0000);
    wait_drain();

    // Back-pressure: result held, start beat refused meanwhile
    ready_force = 1'b0;
    send_beat(1, 0, 32'h12345678, 4'hF, 16'h0000);
    send_beat(0, 1, 32'h9ABCDEF0, 4'hF, 16'h0000);
    begin
      int n;
      n = 0;
      while (!cs_valid_o && n < 20) begin @(posedge clk); #1; n++; end
    end
    in_valid_i = 1'b1; in_start_i = 1'b1; in_last_i = 1'b1;
    in_data_i = $urandom; in_keep_i = 4'hF; init_i = 16'h1234;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid_held", 32'(cs_valid_o), 32'd1);
      check("bp_in_ready_low", 32'(in_ready_o), 32'd0);
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    ready_force = 1'b1;
    wait_drain();

    // Reset mid-packet, then a fresh packet
    send_beat(1, 0, 32'h12345678, 4'hF, 16'h0000);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready_o), 32'd1);
    check("midrst_cs_valid", 32'(cs_valid_o), 32'd0);
    check("midrst_cs_o", 32'(cs_o), 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    in_pkt = 0;
    @(posedge clk); #1;
    send_beat(1, 1, 32'h0001FFFF, 4'hF, 16'h0000);
    wait_drain();

    // Randomised packets with gaps, dropped beats, restarts, random cs_ready_i
    rand_ready = 1;
    for (int p = 0; p < 40; p++) begin
      int len;
      if ($urandom_range(0, 3) == 0)
        send_beat(0, $urandom_range(0, 1), $urandom, 4'($urandom), 16'($urandom));
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        bit st;
        st = (i == 0) || ($urandom_range(0, 9) == 0);
        send_beat(st, i == len - 1, $urandom, 4'($urandom), 16'($urandom));
        idle_cycles($urandom_range(0, 2));
      end
    end
    rand_ready = 0;
    ready_force = 1'b1;
    wait_drain();
    idle_cycles(3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
